gravador_jogada: RTL and testbench

Write controller for the sequence memory in the Genius game datapath. Once a round has been completed, the main control unit hands it a write address. The block then waits for the player to release all buttons and captures the next single valid button press. It writes that press into the sequence RAM in one cycle, then reports either success or timeout back to the control unit over a start/ready handshake.

---
 rtl/gravador_jogada_pkg.sv | 17 +
 rtl/gravador_jogada_detector.sv | 28 ++
 rtl/gravador_jogada.sv | 91 +++++++++
 tb/tb_gravador_jogada.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gravador_jogada_pkg.sv
// Shared definitions for the Genius sequence-memory write controller.
package gravador_jogada_pkg;

    localparam int DATA_W_PADRAO = 4;
    localparam int ADDR_W_PADRAO = 4;

    // 4-bit state codes, also decoded by the control unit's debug display
    typedef enum logic [3:0] {
        OCIOSO        = 4'd0,
        AGUARDA_SOLTA = 4'd1,
        ESPERA        = 4'd2,
        GRAVA         = 4'd3,
        FIM_OK        = 4'd4,
        FIM_TIMEOUT   = 4'd5
    } estado_t;

endpackage

// File: rtl/gravador_jogada_detector.sv
// Valid-press detector: exactly one button pressed, all released on the previous cycle.
module detector_jogada
    import gravador_jogada_pkg::*;
#(
    parameter int DATA_W = DATA_W_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] botoes,
    output logic              jogada_valida
);

    logic [DATA_W-1:0] botoes_r;
    logic              um_bit;

    // previous-cycle sample of the button levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) botoes_r <= '0;
        else       botoes_r <= botoes;
    end

    // one-hot check qualified by a release on the previous cycle
    always_comb begin
        um_bit        = (botoes != '0) && ((botoes & (botoes - DATA_W'(1))) == '0);
        jogada_valida = um_bit && (botoes_r == '0);
    end

endmodule

// File: rtl/gravador_jogada.sv
// Sequence-memory write controller: waits for release, captures one press, writes it.
module gravador_jogada
    import gravador_jogada_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int ADDR_W         = ADDR_W_PADRAO,
    parameter int DATA_W         = DATA_W_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [DATA_W-1:0] botoes,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dado,
    output logic              pronto,
    output logic              gravou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    localparam int              TW        = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [TW-1:0]   TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);

    estado_t           estado, proximo;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] dado_r;
    logic              jogada_valida;

    detector_jogada #(.DATA_W(DATA_W)) u_detector (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .jogada_valida (jogada_valida)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // next-state logic; unused codes fall back to OCIOSO
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:        if (iniciar) proximo = AGUARDA_SOLTA;
            AGUARDA_SOLTA: if (botoes == '0) proximo = ESPERA;
            ESPERA: begin
                if (jogada_valida)           proximo = GRAVA;
                else if (timer == TIMER_FIM) proximo = FIM_TIMEOUT;
            end
            GRAVA:         proximo = FIM_OK;
            FIM_OK:        proximo = OCIOSO;
            FIM_TIMEOUT:   proximo = OCIOSO;
            default:       proximo = OCIOSO;
        endcase
    end

    // timeout timer: cleared while waiting for release, counts during ESPERA
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         timer <= '0;
        else if (estado == AGUARDA_SOLTA)  timer <= '0;
        else if (estado == ESPERA)         timer <= timer + TW'(1);
    end

    // address latched on accepted start, data latched on valid press
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r <= '0;
            dado_r <= '0;
        end else begin
            if (estado == OCIOSO && iniciar)        addr_r <= endereco;
            if (estado == ESPERA && jogada_valida)  dado_r <= botoes;
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        mem_we    = (estado == GRAVA);
        pronto    = (estado == FIM_OK) || (estado == FIM_TIMEOUT);
        gravou    = (estado == FIM_OK);
        timeout   = (estado == FIM_TIMEOUT);
        db_estado = estado;
        mem_addr  = addr_r;
        mem_dado  = dado_r;
    end

endmodule

// File: tb/tb_gravador_jogada.sv
// Self-checking bench for gravador_jogada against an event-level reference model.
module tb_gravador_jogada;

    localparam int T = 8;
    localparam int N = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] endereco = '0;
    logic [3:0] botoes = '0;
    logic       mem_we, pronto, gravou, timeout;
    logic [3:0] mem_addr, mem_dado, db_estado;

    int checks = 0;
    int passes = 0;

    gravador_jogada #(.TIMEOUT_CICLOS(T), .ADDR_W(4), .DATA_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .endereco  (endereco),
        .botoes    (botoes),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_dado  (mem_dado),
        .pronto    (pronto),
        .gravou    (gravou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // stimulus per relative cycle k (k = 0 is the iniciar cycle)
    logic [3:0] stim  [N];
    logic       ini_s [N];
    logic [3:0] end_s [N];
    // observations per relative cycle
    logic [3:0] obs_st [N];
    logic [3:0] obs_addr [N];
    logic [3:0] obs_dado [N];
    logic       obs_we [N];
    logic       obs_pr [N];
    logic       obs_gr [N];
    logic       obs_to [N];
    // reference model results
    logic [3:0] exp_st [N];
    int         e, p, fin;
    bit         found;
    logic [3:0] cur_addr = '0;
    logic [3:0] cur_dado = '0;
    logic       snap_we, snap_pr;
    logic [3:0] snap_st;

    task automatic clear_stim();
        for (int k = 0; k < N; k++) stim[k] = '0;
    endtask

    // Event-level model: release cycle, first qualifying press in the window, finish cycle.
    task automatic build_model(input bit rand_ini, input logic [3:0] a);
        e = N + 1;
        for (int k = 1; k < N; k++) begin
            if (stim[k] == 4'd0) begin
                e = k + 1;
                break;
            end
        end
        found = 1'b0;
        p = -1;
        for (int k = e; k < e + T && k < N; k++) begin
            if (!found && $countones(stim[k]) == 1 && stim[k-1] == 4'd0) begin
                found = 1'b1;
                p = k;
            end
        end
        fin = found ? p + 2 : e + T;
        for (int k = 0; k < N; k++) begin
            if (k == 0)                   exp_st[k] = 4'd0;
            else if (k < e)               exp_st[k] = 4'd1;
            else if (found && k <= p)     exp_st[k] = 4'd2;
            else if (!found && k < fin)   exp_st[k] = 4'd2;
            else if (found && k == p + 1) exp_st[k] = 4'd3;
            else if (k == fin)            exp_st[k] = found ? 4'd4 : 4'd5;
            else                          exp_st[k] = 4'd0;
            ini_s[k] = (k == 0) ? 1'b1 : ((rand_ini && k <= fin) ? 1'($urandom_range(0, 1)) : 1'b0);
            end_s[k] = (k == 0) ? a : 4'($urandom);
        end
        cur_addr = a;
        if (found) cur_dado = stim[p];
    endtask

    // Drive one operation and record outputs at each negedge; optional async reset at cycle rst_at.
    task automatic play(input int rst_at);
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            if (rst_at >= 0 && k == rst_at + 1) reset = 1'b0;
            obs_st[k]   = db_estado;
            obs_we[k]   = mem_we;
            obs_pr[k]   = pronto;
            obs_gr[k]   = gravou;
            obs_to[k]   = timeout;
            obs_addr[k] = mem_addr;
            obs_dado[k] = mem_dado;
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                snap_we = mem_we;
                snap_pr = pronto;
                snap_st = db_estado;
            end
            iniciar  = ini_s[k];
            endereco = end_s[k];
            botoes   = stim[k];
        end
        @(negedge clock);
        iniciar = 1'b0;
        botoes  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({mem_we, pronto, gravou, timeout, db_estado, mem_addr, mem_dado} !== 16'h0)
            $display("FAIL reset_hold: got we=%b pr=%b gr=%b to=%b st=%0d addr=%h dado=%h, expected all zero",
                     mem_we, pronto, gravou, timeout, db_estado, mem_addr, mem_dado);
        else passes++;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({mem_we, pronto, gravou, timeout, db_estado, mem_addr, mem_dado} !== 16'h0)
            $display("FAIL reset_release: got st=%0d addr=%h dado=%h, expected all zero",
                     db_estado, mem_addr, mem_dado);
        else passes++;
    endtask

    task automatic test_press_basic();
        logic [3:0] seq [8];
        seq = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd0};
        clear_stim();
        stim[4] = 4'b0100;
        build_model(1'b0, 4'h5);
        play(-1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs_st[k] !== seq[k])
                $display("FAIL basic_state[%0d]: got %0d expected %0d", k, obs_st[k], seq[k]);
            else passes++;
        end
        checks++;
        if ({obs_we[5], obs_addr[5], obs_dado[5]} !== {1'b1, 4'h5, 4'b0100})
            $display("FAIL basic_write: got we=%b addr=%h dado=%b expected we=1 addr=5 dado=0100",
                     obs_we[5], obs_addr[5], obs_dado[5]);
        else passes++;
        checks++;
        if ({obs_pr[6], obs_gr[6], obs_to[6]} !== 3'b110)
            $display("FAIL basic_done: got pr=%b gr=%b to=%b expected 1 1 0", obs_pr[6], obs_gr[6], obs_to[6]);
        else passes++;
    endtask

    task automatic test_held_button();
        clear_stim();
        for (int k = 0; k < 6; k++) stim[k] = 4'b0001;
        stim[8] = 4'b1000;
        build_model(1'b1, 4'hA);
        play(-1);
        checks++;
        if ({obs_st[3], obs_st[6], obs_st[7]} !== {4'd1, 4'd1, 4'd2})
            $display("FAIL held_states: got %0d,%0d,%0d expected 1,1,2", obs_st[3], obs_st[6], obs_st[7]);
        else passes++;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs_we[k] !== (k == 9))
                $display("FAIL held_we[%0d]: got %b expected %b", k, obs_we[k], (k == 9));
            else passes++;
        end
        checks++;
        if ({obs_dado[9], obs_addr[9]} !== {4'b1000, 4'hA})
            $display("FAIL held_data: got dado=%b addr=%h expected 1000 a", obs_dado[9], obs_addr[9]);
        else passes++;
    endtask

    task automatic test_multibit();
        int pulses;
        clear_stim();
        stim[3] = 4'b0011;
        stim[5] = 4'b0010;
        build_model(1'b1, 4'h2);
        play(-1);
        pulses = 0;
        for (int k = 0; k < N; k++) if (obs_we[k] === 1'b1) pulses++;
        checks++;
        if (pulses != 1) $display("FAIL multibit_pulses: got %0d expected 1", pulses);
        else passes++;
        checks++;
        if ({obs_we[6], obs_dado[6], mem_dado} !== {1'b1, 4'b0010, 4'b0010})
            $display("FAIL multibit_data: got we=%b dado=%b final=%b expected 1 0010 0010",
                     obs_we[6], obs_dado[6], mem_dado);
        else passes++;
    endtask

    task automatic test_timeout();
        logic [3:0] prev_dado;
        int pulses;
        prev_dado = cur_dado;
        clear_stim();
        build_model(1'b1, 4'h7);
        play(-1);
        checks++;
        if ({obs_st[9], obs_pr[9]} !== {4'd2, 1'b0})
            $display("FAIL timeout_early: got st=%0d pr=%b expected 2 0", obs_st[9], obs_pr[9]);
        else passes++;
        checks++;
        if ({obs_st[10], obs_pr[10], obs_to[10], obs_gr[10]} !== {4'd5, 1'b1, 1'b1, 1'b0})
            $display("FAIL timeout_done: got st=%0d pr=%b to=%b gr=%b expected 5 1 1 0",
                     obs_st[10], obs_pr[10], obs_to[10], obs_gr[10]);
        else passes++;
        pulses = 0;
        for (int k = 0; k < N; k++) if (obs_we[k] === 1'b1 || obs_gr[k] === 1'b1) pulses++;
        checks++;
        if (pulses != 0) $display("FAIL timeout_nowrite: got %0d we/gravou cycles expected 0", pulses);
        else passes++;
        checks++;
        if ({mem_dado, mem_addr} !== {prev_dado, 4'h7})
            $display("FAIL timeout_regs: got dado=%b addr=%h expected %b 7", mem_dado, mem_addr, prev_dado);
        else passes++;
    endtask

    task automatic test_terminal_press();
        clear_stim();
        stim[9] = 4'b0100;
        build_model(1'b1, 4'hC);
        play(-1);
        checks++;
        if ({obs_we[10], obs_dado[10]} !== {1'b1, 4'b0100})
            $display("FAIL terminal_write: got we=%b dado=%b expected 1 0100", obs_we[10], obs_dado[10]);
        else passes++;
        checks++;
        if ({obs_pr[11], obs_gr[11], obs_to[11]} !== 3'b110)
            $display("FAIL terminal_done: got pr=%b gr=%b to=%b expected 1 1 0",
                     obs_pr[11], obs_gr[11], obs_to[11]);
        else passes++;
    endtask

    task automatic test_reset_in_grava();
        int pulses;
        clear_stim();
        stim[3] = 4'b0010;
        build_model(1'b0, 4'h9);
        play(4);
        cur_addr = '0;
        cur_dado = '0;
        checks++;
        if (obs_we[4] !== 1'b1) $display("FAIL abort_grava_entry: got we=%b expected 1", obs_we[4]);
        else passes++;
        checks++;
        if ({snap_we, snap_pr, snap_st} !== 6'b0)
            $display("FAIL abort_async: got we=%b pr=%b st=%0d expected 0 0 0", snap_we, snap_pr, snap_st);
        else passes++;
        pulses = 0;
        for (int k = 5; k < N; k++) if (obs_pr[k] !== 1'b0 || obs_st[k] !== 4'd0) pulses++;
        checks++;
        if (pulses != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", pulses);
        else passes++;
        checks++;
        if ({mem_addr, mem_dado} !== 8'h00)
            $display("FAIL abort_regs: got addr=%h dado=%b expected 0 0", mem_addr, mem_dado);
        else passes++;
        clear_stim();
        stim[2] = 4'b1000;
        build_model(1'b0, 4'h3);
        play(-1);
        checks++;
        if ({obs_we[3], obs_gr[4], mem_addr, mem_dado} !== {1'b1, 1'b1, 4'h3, 4'b1000})
            $display("FAIL abort_recover: got we=%b gr=%b addr=%h dado=%b expected 1 1 3 1000",
                     obs_we[3], obs_gr[4], mem_addr, mem_dado);
        else passes++;
    endtask

    task automatic test_random();
        logic [3:0] nopress [4];
        logic       exp_we, exp_pr, exp_gr, exp_to;
        int         errs;
        nopress = '{4'b0000, 4'b0011, 4'b1100, 4'b1111};
        for (int it = 0; it < 30; it++) begin
            bool_mode: begin
                bit starve;
                starve = ($urandom_range(0, 3) == 0);
                for (int k = 0; k < N; k++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (starve && k >= 1)  stim[k] = nopress[$urandom_range(0, 3)];
                    else if (r < 4)        stim[k] = 4'b0000;
                    else if (r < 8)        stim[k] = 4'(1 << $urandom_range(0, 3));
                    else                   stim[k] = 4'($urandom);
                end
                stim[12] = 4'b0000;
            end
            build_model(1'b1, 4'($urandom));
            play(-1);
            errs = 0;
            for (int k = 0; k < N; k++) begin
                exp_we = found && (k == p + 1);
                exp_pr = (k == fin);
                exp_gr = found && (k == fin);
                exp_to = !found && (k == fin);
                checks++;
                if ({obs_st[k], obs_we[k], obs_pr[k], obs_gr[k], obs_to[k]} !==
                    {exp_st[k], exp_we, exp_pr, exp_gr, exp_to}) begin
                    if (errs < 4)
                        $display("FAIL rand%0d_cycle%0d: got st=%0d we=%b pr=%b gr=%b to=%b expected st=%0d we=%b pr=%b gr=%b to=%b",
                                 it, k, obs_st[k], obs_we[k], obs_pr[k], obs_gr[k], obs_to[k],
                                 exp_st[k], exp_we, exp_pr, exp_gr, exp_to);
                    errs++;
                end else passes++;
            end
            checks++;
            if ({mem_addr, mem_dado} !== {cur_addr, cur_dado})
                $display("FAIL rand%0d_regs: got addr=%h dado=%b expected addr=%h dado=%b",
                         it, mem_addr, mem_dado, cur_addr, cur_dado);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_press_basic();
        test_held_button();
        test_multibit();
        test_timeout();
        test_terminal_press();
        test_reset_in_grava();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
